// File: rtl/axis_frame_arbiter_pkg.sv
// rtl/axis_frame_arbiter_pkg.sv - shared state encoding and ID width helper for the frame arbiter
package axis_frame_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } arb_state_t;

  // A single requester still needs a 1-bit index field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_frame_arbiter_rr_arbiter_core.sv
// rtl/axis_frame_arbiter_rr_arbiter_core.sv - combinational round-robin priority encoder
module rr_arbiter_core
  import axis_frame_arbiter_pkg::*;
#(
  parameter int S_COUNT  = 4,
  parameter int ID_WIDTH = id_width(S_COUNT)
) (
  input  logic [S_COUNT-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_last_idx,
  output logic                o_valid,
  output logic [ID_WIDTH-1:0] o_idx,
  output logic [S_COUNT-1:0]  o_onehot
);

  // Scan from the farthest candidate back towards last+1 so the nearest one above wins.
  always_comb begin
    int cand;
    o_valid  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    cand     = 0;
    for (int k = S_COUNT; k >= 1; k--) begin
      cand = (int'(i_last_idx) + k) % S_COUNT;
      if (i_req[cand]) begin
        o_valid = 1'b1;
        o_idx   = ID_WIDTH'(cand);
      end
    end
    if (o_valid) o_onehot[o_idx] = 1'b1;
  end

endmodule

// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - frame-granular round-robin arbiter feeding one AXI-Stream sink
module axis_frame_arbiter
  import axis_frame_arbiter_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = id_width(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          status_busy,
  output logic [ID_WIDTH-1:0]           status_grant_index
);

  arb_state_t            r_state;
  logic [ID_WIDTH-1:0]   r_grant_idx;
  logic [ID_WIDTH-1:0]   r_last_idx;
  logic [S_COUNT-1:0]    r_tready;
  logic                  r_ready_int;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;
  logic [ID_WIDTH-1:0]   r_out_id;
  logic [USER_WIDTH-1:0] r_out_user;

  logic                  r_temp_valid;
  logic [DATA_WIDTH-1:0] r_temp_data;
  logic                  r_temp_last;
  logic [ID_WIDTH-1:0]   r_temp_id;
  logic [USER_WIDTH-1:0] r_temp_user;

  logic                  w_arb_valid;
  logic [ID_WIDTH-1:0]   w_arb_idx;
  logic [S_COUNT-1:0]    w_arb_onehot;
  logic [S_COUNT-1:0]    w_grant_onehot;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last;
  logic [USER_WIDTH-1:0] w_sel_user;

  logic                  w_ready_early;
  logic                  w_out_valid_next;
  logic                  w_temp_valid_next;
  logic                  w_in_to_out;
  logic                  w_in_to_temp;
  logic                  w_temp_to_out;

  rr_arbiter_core #(
    .S_COUNT  (S_COUNT),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .i_req      (s_axis_tvalid),
    .i_last_idx (r_last_idx),
    .o_valid    (w_arb_valid),
    .o_idx      (w_arb_idx),
    .o_onehot   (w_arb_onehot)
  );

  assign w_grant_onehot = S_COUNT'(1) << r_grant_idx;
  assign w_accept       = |(s_axis_tvalid & r_tready);
  assign w_sel_data     = s_axis_tdata[int'(r_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_user     = s_axis_tuser[int'(r_grant_idx)*USER_WIDTH +: USER_WIDTH];
  assign w_sel_last     = s_axis_tlast[r_grant_idx];

  // Ready for next cycle is decided from registered state, so m_axis_tready never reaches s_axis_tready combinationally.
  always_comb begin
    w_ready_early     = m_axis_tready || (!r_temp_valid && (!r_out_valid || !w_accept));
    w_out_valid_next  = r_out_valid;
    w_temp_valid_next = r_temp_valid;
    w_in_to_out       = 1'b0;
    w_in_to_temp      = 1'b0;
    w_temp_to_out     = 1'b0;
    if (r_ready_int) begin
      if (m_axis_tready || !r_out_valid) begin
        w_out_valid_next = w_accept;
        w_in_to_out      = w_accept;
      end else begin
        w_temp_valid_next = w_accept;
        w_in_to_temp      = w_accept;
      end
    end else if (m_axis_tready) begin
      w_out_valid_next  = r_temp_valid;
      w_temp_valid_next = 1'b0;
      w_temp_to_out     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant_idx <= '0;
      r_last_idx  <= ID_WIDTH'(S_COUNT - 1);
      r_tready    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_state     <= ST_ACTIVE;
            r_grant_idx <= w_arb_idx;
            r_tready    <= w_arb_onehot & {S_COUNT{w_ready_early}};
          end else begin
            r_tready <= '0;
          end
        end
        ST_ACTIVE: begin
          if (w_accept && w_sel_last) begin
            r_state    <= ST_IDLE;
            r_last_idx <= r_grant_idx;
            r_tready   <= '0;
          end else begin
            r_tready <= w_grant_onehot & {S_COUNT{w_ready_early}};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready_int  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_out_id     <= '0;
      r_out_user   <= '0;
      r_temp_valid <= 1'b0;
      r_temp_data  <= '0;
      r_temp_last  <= 1'b0;
      r_temp_id    <= '0;
      r_temp_user  <= '0;
    end else begin
      r_ready_int  <= w_ready_early;
      r_out_valid  <= w_out_valid_next;
      r_temp_valid <= w_temp_valid_next;
      if (w_in_to_out) begin
        r_out_data <= w_sel_data;
        r_out_last <= w_sel_last;
        r_out_id   <= r_grant_idx;
        r_out_user <= w_sel_user;
      end else if (w_temp_to_out) begin
        r_out_data <= r_temp_data;
        r_out_last <= r_temp_last;
        r_out_id   <= r_temp_id;
        r_out_user <= r_temp_user;
      end
      if (w_in_to_temp) begin
        r_temp_data <= w_sel_data;
        r_temp_last <= w_sel_last;
        r_temp_id   <= r_grant_idx;
        r_temp_user <= w_sel_user;
      end
    end
  end

  assign s_axis_tready      = r_tready;
  assign m_axis_tdata       = r_out_data;
  assign m_axis_tvalid      = r_out_valid;
  assign m_axis_tlast       = r_out_last;
  assign m_axis_tid         = r_out_id;
  assign m_axis_tuser       = r_out_user;
  assign status_busy        = (r_state == ST_ACTIVE);
  assign status_grant_index = r_grant_idx;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb/tb_axis_frame_arbiter.sv - scoreboard bench for the round-robin frame arbiter
`timescale 1ns/1ps
module tb_axis_frame_arbiter;

  localparam int S         = 4;
  localparam int DW        = 8;
  localparam int UW        = 1;
  localparam int IW        = 2;
  localparam int PAUSE_LEN = 5;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [S*DW-1:0] s_tdata = '0;
  logic [S-1:0]    s_tvalid = '0;
  logic [S-1:0]    s_tready;
  logic [S-1:0]    s_tlast = '0;
  logic [S*UW-1:0] s_tuser = '0;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic            m_tlast;
  logic [IW-1:0]   m_tid;
  logic [UW-1:0]   m_tuser;
  logic            busy;
  logic [IW-1:0]   grant;

  axis_frame_arbiter #(
    .S_COUNT    (S),
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW),
    .ID_WIDTH   (IW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis_tdata       (s_tdata),
    .s_axis_tvalid      (s_tvalid),
    .s_axis_tready      (s_tready),
    .s_axis_tlast       (s_tlast),
    .s_axis_tuser       (s_tuser),
    .m_axis_tdata       (m_tdata),
    .m_axis_tvalid      (m_tvalid),
    .m_axis_tready      (m_tready),
    .m_axis_tlast       (m_tlast),
    .m_axis_tid         (m_tid),
    .m_axis_tuser       (m_tuser),
    .status_busy        (busy),
    .status_grant_index (grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t src_q[S][$];
  beat_t exp_q[S][$];
  int    exp_order[$];
  int    sent[S];
  int    pause_after[S];
  int    hold[S];
  bit    fire[S];
  bit    tog, in_frame, t3_on, t5_watch, t5_viol, hold_v;
  int    cur_tid, t3_prev;
  logic [31:0] hold_beat;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input int s, input int n, input logic [7:0] base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + 8'(k);
      b.last = (k == n - 1);
      b.user = b.data[0];
      src_q[s].push_back(b);
      exp_q[s].push_back(b);
    end
  endtask

  function automatic int pending();
    int p = exp_order.size();
    for (int i = 0; i < S; i++) p += src_q[i].size() + exp_q[i].size();
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, pending(), 0);
  endtask

  task automatic wait_sent(input int s, input int cnt, input string tag);
    int n = 0;
    while (sent[s] < cnt && n < 100) begin
      tick();
      n++;
    end
    chk(tag, sent[s] >= cnt, 1);
  endtask

  // Source model: pops a beat one edge after the handshake was seen, then presents the next one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < S; i++) begin
        if (fire[i] && src_q[i].size() > 0) begin
          if (i == 1 && src_q[i][0].last) t5_watch = 0;
          void'(src_q[i].pop_front());
          sent[i]++;
          if (sent[i] == pause_after[i]) hold[i] = PAUSE_LEN;
        end
        fire[i] = 0;
        if (rst) s_tvalid[i] = 1'b0;
        else if (hold[i] > 0) begin
          s_tvalid[i] = 1'b0;
          hold[i]--;
        end else s_tvalid[i] = (src_q[i].size() > 0);
        if (src_q[i].size() > 0) begin
          s_tdata[i*DW +: DW] = src_q[i][0].data;
          s_tlast[i]          = src_q[i][0].last;
          s_tuser[i*UW +: UW] = src_q[i][0].user;
        end
      end
      if (tog) m_tready = !m_tready;
    end
  end

  // Output monitor and scoreboard.
  initial begin
    beat_t e;
    int t;
    forever begin
      @(negedge clk);
      for (int i = 0; i < S; i++) fire[i] = s_tvalid[i] & s_tready[i];
      if (t5_watch && s_tready[3]) t5_viol = 1;
      if (rst) hold_v = 0;
      else begin
        if (hold_v) begin
          chk("axi_hold_valid", m_tvalid, 1);
          chk("axi_hold_beat", {m_tdata, m_tlast, m_tid, m_tuser}, hold_beat);
        end
        hold_v    = m_tvalid && !m_tready;
        hold_beat = {20'd0, m_tdata, m_tlast, m_tid, m_tuser};
        if (m_tvalid && m_tready) begin
          t = int'(m_tid);
          if (!in_frame) begin
            if (exp_order.size() == 0) chk("order_extra_frame", 1, 0);
            else chk("order_tid", m_tid, exp_order.pop_front());
            in_frame = 1;
            cur_tid  = t;
          end else chk("no_interleave", m_tid, cur_tid);
          if (exp_q[t].size() == 0) chk("beat_extra", 1, 0);
          else begin
            e = exp_q[t].pop_front();
            chk("beat", {m_tdata, m_tlast, m_tuser}, {e.data, e.last, e.user});
          end
          if (m_tlast) in_frame = 0;
          if (t3_on) begin
            if (t3_prev >= 0) chk("t3_gap", cyc - t3_prev, 2);
            t3_prev = cyc;
          end
        end
      end
    end
  end

  initial begin
    int n, t0;
    for (int i = 0; i < S; i++) begin
      sent[i] = 0;
      pause_after[i] = -1;
      hold[i] = 0;
      fire[i] = 0;
    end
    tog = 0; in_frame = 0; t3_on = 0; t5_watch = 0; t5_viol = 0; hold_v = 0;
    cur_tid = 0; t3_prev = -1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", s_tready, 0);
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    tick();
    rst = 0;

    // Streams 0 and 2 together: whole frame of 0, then whole frame of 2.
    send_frame(0, 3, 8'hA0);
    send_frame(2, 3, 8'hC0);
    exp_order.push_back(0);
    exp_order.push_back(2);
    n = 0;
    @(negedge clk);
    while (s_tvalid == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    n = 0;
    while (!m_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t2_latency", cyc - t0, 2);
    wait_drain("t2_drain", 60);

    // All four streams with single-beat frames; last grant was 2.
    t3_on = 1;
    t3_prev = -1;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < S; s++) send_frame(s, 1, 8'((s << 4) | k));
      for (int j = 0; j < S; j++) exp_order.push_back((3 + j) % S);
    end
    wait_drain("t3_drain", 100);
    t3_on = 0;

    tog = 1;
    send_frame(0, 8, 8'h00);
    exp_order.push_back(0);
    wait_drain("t4_drain", 100);
    tog = 0;
    m_tready = 1;

    // Stream 1 pauses mid-frame while stream 3 waits.
    for (int i = 0; i < S; i++) sent[i] = 0;
    pause_after[1] = 2;
    send_frame(1, 6, 8'h50);
    exp_order.push_back(1);
    wait_sent(1, 1, "t5_start");
    t5_viol = 0;
    t5_watch = 1;
    send_frame(3, 2, 8'h90);
    exp_order.push_back(3);
    wait_sent(1, 2, "t5_two_beats");
    tick();
    tick();
    @(negedge clk);
    chk("t5_busy_paused", busy, 1);
    chk("t5_grant_paused", grant, 1);
    chk("t5_tready3_paused", s_tready[3], 0);
    wait_drain("t5_drain", 100);
    chk("t5_ready3_blocked", t5_viol, 0);
    pause_after[1] = -1;

    // Reset in the middle of a 4-beat frame from stream 1.
    tick();
    sent[1] = 0;
    send_frame(1, 4, 8'h60);
    exp_order.push_back(1);
    wait_sent(1, 2, "t6_two_beats");
    rst = 1;
    m_tready = 0;
    tick();
    chk("t6_rst_outputs", {s_tready, m_tvalid, m_tdata, m_tlast, m_tid, m_tuser, grant}, 0);
    chk("t6_rst_busy", busy, 0);
    rst = 0;
    for (int i = 0; i < S; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      hold[i] = 0;
    end
    exp_order.delete();
    in_frame = 0;
    m_tready = 1;
    send_frame(2, 4, 8'h70);
    exp_order.push_back(2);
    wait_drain("t6_drain", 60);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
